eth_tx_frame_arbiter: RTL and testbench
=======================================

Name: eth_tx_frame_arbiter

Overview:
- Frame-granular arbiter that shares the MAC TX AXI-stream byte port (8-bit tdata/tvalid/tready/tlast/tuser) between NUM_SRC uDMA TX requesters.
- Grants one source per frame using round-robin and holds the grant until that source's tlast.
- Enforces a maximum frame length and keeps per-block sent/aborted frame counters.
- Sits between the uDMA ethernet TX channels and the RGMII MAC core in the clk_i (125 MHz) domain.

Parameters:
- NUM_SRC, 4, number of requesting byte streams (2..8).
- MAX_FRAME_LEN, 1518, maximum beats per frame before a forced abort (16-bit range).
- CNT_W, 16, width of the frame counters.

Ports:
- clk_i  in  1  block clock, 125 MHz, same as MAC logic clock.
- rstn_i  in  1  asynchronous active-low reset.
- cfg_enable_i  in  1  arbitration enable; 0 means no new grants are issued.
- cfg_src_mask_i  in  NUM_SRC  per-source eligibility; 1 = eligible.
- src_tdata_i  in  NUM_SRC*8  packed source data; source k uses bits [8k+7:8k].
- src_tvalid_i  in  NUM_SRC  source valid.
- src_tlast_i  in  NUM_SRC  source end of frame.
- src_tuser_i  in  NUM_SRC  source bad-frame marker.
- src_tready_o  out  NUM_SRC  source ready.
- mac_tdata_o  out  8  data to the MAC.
- mac_tvalid_o  out  1  valid to the MAC.
- mac_tlast_o  out  1  last to the MAC.
- mac_tuser_o  out  1  bad-frame marker to the MAC.
- mac_tready_i  in  1  ready from the MAC.
- grant_o  out  NUM_SRC  one-hot current grant; 0 when idle.
- busy_o  out  1  high in XFER or DRAIN.
- frames_sent_o  out  CNT_W  count of frames completed normally.
- frames_aborted_o  out  CNT_W  count of frames truncated at MAX_FRAME_LEN.

Behaviour:
- Reset (rstn_i=0, asynchronous): state=IDLE, grant_o=0, rr pointer=NUM_SRC-1, beat counter=0, both frame counters=0. All mac_* outputs 0, src_tready_o=0, busy_o=0.
- IDLE:
  - req = src_tvalid_i & cfg_src_mask_i.
  - If cfg_enable_i and req≠0: register a grant for the first requester searching from pointer+1 upward (mod NUM_SRC), then go to XFER.
  - Arbitration latency is one cycle from tvalid to grant.
- XFER, granted source g, combinational pass-through with zero latency:
  - mac_tdata_o/tvalid/tlast/tuser = src_*[g].
  - src_tready_o[g] = mac_tready_i; all other readies are 0.
  - Beat counter increments on every handshake (valid & ready).
  - On a handshake with tlast: frames_sent++, pointer=g, counter=0, grant_o=0, go to IDLE. This gives at least one bubble cycle between frames.
  - On a handshake at beat MAX_FRAME_LEN without tlast: force mac_tlast_o=1 and mac_tuser_o=1 on that beat, frames_aborted++, go to DRAIN.
  - If tlast and the length limit coincide on the same beat, the frame counts as a normal completion and is passed through unmodified.
- DRAIN:
  - mac_tvalid_o=0; src_tready_o[g]=1. Source beats are discarded until g's tlast.
  - Then pointer=g, go to IDLE.
- cfg_enable_i or cfg_src_mask_i changes mid-frame do not affect the granted frame. They are sampled only in IDLE.
- The source must hold tvalid and data stable until ready (AXI rule). The arbiter never deasserts tvalid mid-beat toward the MAC.
- Counters saturate at all-ones; they do not wrap.
- A source with tuser=1 on its tlast is passed through unchanged and counts as sent.

Optional Feature:
- ETH_TX_ARB_PRIO_EN defined: source 0 has strict priority. If req[0] is set in IDLE it wins regardless of the pointer, and the pointer is not updated after a source-0 frame. Other sources remain round-robin.
- ETH_TX_ARB_PRIO_EN undefined: pure round-robin over all sources.

Decomposition:
- Package eth_tx_arb_pkg holds:
  - state enum {IDLE, XFER, DRAIN};
  - default constants MAX_FRAME_LEN_DEF=1518 and CNT_W_DEF=16;
  - a function for a one-hot to index conversion.
- Sub-module eth_rr_arbiter: combinational round-robin pick (req, pointer → one-hot grant, valid), parameterised by NUM_SRC. The top level owns the registers.

Test Plan:
- Src1 sends a 64-byte frame, mac_tready_i=1 → grant_o=4'b0010 one cycle after tvalid. 64 beats arrive on the MAC with byte-identical data and tlast on beat 64. frames_sent_o=1.
- All four sources request continuously with 10-byte frames → grants in order 0,1,2,3,0. Exactly one idle cycle between frames. No source interleaving within a frame.
- MAX_FRAME_LEN=20, src2 sends 30 beats → MAC sees 20 beats, with tlast=1 and tuser=1 on beat 20. Beats 21–30 are drained with mac_tvalid_o=0. frames_aborted_o=1, then the next request is granted.
- mac_tready_i toggles 1010… during a 16-byte frame → exactly 16 handshakes, no data loss or duplication, and src_tready_o mirrors mac_tready_i for the granted source only.
- cfg_src_mask_i=4'b1011 with src2 requesting → no grant to src2. Clearing cfg_enable_i mid-frame of src0 → frame completes, then grant_o stays 0.
- Assert rstn_i low mid-frame at beat 5 → all outputs are 0 immediately (asynchronously). After release, the first grant goes to src0 (pointer=3).

Source files
------------

// File: rtl/eth_tx_arb_pkg.sv
// Shared types and helpers for the ethernet TX frame arbiter.
// Holds the FSM state enum, default sizing constants and oh2idx().
package eth_tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DRAIN
  } arb_state_e;

  localparam int MAX_FRAME_LEN_DEF = 1518;
  localparam int CNT_W_DEF         = 16;
  localparam int SRC_MAX           = 8;

  // OR of indices of set bits; exact for a one-hot input.
  function automatic logic [2:0] oh2idx(
    input logic [SRC_MAX-1:0] oh
  );
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < SRC_MAX; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/eth_tx_frame_arbiter_if.sv
// 8-bit AXI-stream byte bundle toward the MAC (tdata/tvalid/tready/tlast/tuser).
// master drives data side and samples tready; slave is the MAC view.
interface eth_tx_frame_arbiter_if;

  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;
  logic       tuser;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    output tuser,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    input  tuser,
    output tready
  );

endinterface

// File: rtl/eth_rr_arbiter.sv
// Combinational round-robin pick: first req above ptr (mod NUM_SRC).
// Ports: req, ptr in; gnt one-hot out, vld = any request.
module eth_rr_arbiter #(
  parameter  int NUM_SRC = 4,
  localparam int IW      = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_SRC-1:0] gnt,
  output logic               vld
);

  logic [IW-1:0] idx;

  // Walk from farthest to nearest so the nearest hit wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int i = NUM_SRC; i >= 1; i--) begin
      idx = IW'((int'(ptr) + i) % NUM_SRC);
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
      end
    end
  end

  assign vld = |req;

endmodule

// File: rtl/eth_tx_frame_arbiter.sv
// Frame-granular RR arbiter of NUM_SRC byte streams onto one MAC TX port.
// Ports: clk_i/rstn_i, cfg_*, src_* streams, mac (if.master), grant_o, busy_o, counters.
// ETH_TX_ARB_PRIO_EN: source 0 gets strict priority and leaves ptr untouched.
module eth_tx_frame_arbiter
  import eth_tx_arb_pkg::*;
#(
  parameter int NUM_SRC       = 4,
  parameter int MAX_FRAME_LEN = MAX_FRAME_LEN_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   cfg_enable_i,
  input  logic [NUM_SRC-1:0]     cfg_src_mask_i,
  input  logic [NUM_SRC*8-1:0]   src_tdata_i,
  input  logic [NUM_SRC-1:0]     src_tvalid_i,
  input  logic [NUM_SRC-1:0]     src_tlast_i,
  input  logic [NUM_SRC-1:0]     src_tuser_i,
  output logic [NUM_SRC-1:0]     src_tready_o,
  eth_tx_frame_arbiter_if.master mac,
  output logic [NUM_SRC-1:0]     grant_o,
  output logic                   busy_o,
  output logic [CNT_W-1:0]       frames_sent_o,
  output logic [CNT_W-1:0]       frames_aborted_o
);

  localparam int IW = $clog2(NUM_SRC);

  arb_state_e          state_q, state_d;
  logic [NUM_SRC-1:0]  grant_q, grant_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [15:0]         beat_q, beat_d;
  logic [CNT_W-1:0]    sent_q, abort_q;
  logic                sent_inc, abort_inc;

  logic [NUM_SRC-1:0]  req, rr_gnt, pick;
  logic                rr_vld;
  logic [IW-1:0]       gidx, ptr_upd;

  logic [NUM_SRC-1:0][7:0] data_arr;
  logic [7:0]          sel_data;
  logic                sel_valid, sel_last, sel_user;
  logic                at_max;

  assign req = src_tvalid_i & cfg_src_mask_i;

  eth_rr_arbiter #(
    .NUM_SRC (NUM_SRC)
  ) u_rr (
    .req (req),
    .ptr (ptr_q),
    .gnt (rr_gnt),
    .vld (rr_vld)
  );

  assign gidx      = IW'(oh2idx(SRC_MAX'(grant_q)));
  assign data_arr  = src_tdata_i;
  assign sel_data  = data_arr[gidx];
  assign sel_valid = src_tvalid_i[gidx];
  assign sel_last  = src_tlast_i[gidx];
  assign sel_user  = src_tuser_i[gidx];

  // Beat index (1-based) equals MAX_FRAME_LEN on the presented beat.
  assign at_max = (beat_q == 16'(MAX_FRAME_LEN - 1));

`ifdef ETH_TX_ARB_PRIO_EN
  assign pick    = req[0] ? NUM_SRC'(1) : rr_gnt;
  assign ptr_upd = (gidx == '0) ? ptr_q : gidx;
`else
  assign pick    = rr_gnt;
  assign ptr_upd = gidx;
`endif

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    ptr_d        = ptr_q;
    beat_d       = beat_q;
    sent_inc     = 1'b0;
    abort_inc    = 1'b0;
    src_tready_o = '0;
    mac.tdata    = '0;
    mac.tvalid   = 1'b0;
    mac.tlast    = 1'b0;
    mac.tuser    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg_enable_i && rr_vld) begin
          grant_d = pick;
          beat_d  = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        mac.tdata    = sel_data;
        mac.tvalid   = sel_valid;
        // Forced end is held for the whole beat, stalls included.
        mac.tlast    = sel_last | at_max;
        mac.tuser    = sel_user | (at_max & ~sel_last);
        src_tready_o = grant_q & {NUM_SRC{mac.tready}};
        if (sel_valid && mac.tready) begin
          beat_d = beat_q + 16'd1;
          if (sel_last) begin
            sent_inc = 1'b1;
            ptr_d    = ptr_upd;
            grant_d  = '0;
            beat_d   = '0;
            state_d  = IDLE;
          end else if (at_max) begin
            abort_inc = 1'b1;
            beat_d    = '0;
            state_d   = DRAIN;
          end
        end
      end
      DRAIN: begin
        src_tready_o = grant_q;
        if (sel_valid && sel_last) begin
          ptr_d   = ptr_upd;
          grant_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= IW'(NUM_SRC - 1);
      beat_q  <= '0;
      sent_q  <= '0;
      abort_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      beat_q  <= beat_d;
      if (sent_inc && sent_q != '1)
        sent_q <= sent_q + CNT_W'(1);
      if (abort_inc && abort_q != '1)
        abort_q <= abort_q + CNT_W'(1);
    end
  end

  assign grant_o          = grant_q;
  assign busy_o           = (state_q != IDLE);
  assign frames_sent_o    = sent_q;
  assign frames_aborted_o = abort_q;

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Directed bench for eth_tx_frame_arbiter (MAX_FRAME_LEN=20, CNT_W=3).
// Source models stream a known byte pattern; MAC beats are logged and checked.
module tb_eth_tx_frame_arbiter;

  localparam int N    = 4;
  localparam int MAXL = 20;
  localparam int CW   = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           cfg_en = 1'b0;
  logic [N-1:0]   cfg_mask = '1;
  logic [N*8-1:0] s_data;
  logic [N-1:0]   s_valid, s_last, s_user, s_ready, grant;
  logic           busy;
  logic [CW-1:0]  n_sent, n_abort;

  eth_tx_frame_arbiter_if mac();

  eth_tx_frame_arbiter #(
    .NUM_SRC       (N),
    .MAX_FRAME_LEN (MAXL),
    .CNT_W         (CW)
  ) dut (
    .clk_i            (clk),
    .rstn_i           (rst_n),
    .cfg_enable_i     (cfg_en),
    .cfg_src_mask_i   (cfg_mask),
    .src_tdata_i      (s_data),
    .src_tvalid_i     (s_valid),
    .src_tlast_i      (s_last),
    .src_tuser_i      (s_user),
    .src_tready_o     (s_ready),
    .mac              (mac),
    .grant_o          (grant),
    .busy_o           (busy),
    .frames_sent_o    (n_sent),
    .frames_aborted_o (n_abort)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  logic tog = 1'b0;

  assign mac.tready = tog ? cyc[0] : 1'b1;

  int   flen[N] = '{default: 1};
  int   nreq[N] = '{default: 0};
  int   done[N] = '{default: 0};
  int   pos[N]  = '{default: 0};
  int   nf[N]   = '{default: 0};
  logic hs[N]   = '{default: 1'b0};

  function automatic logic [7:0] pat(int k, int f, int p);
    return 8'(k * 64 + f * 16 + p);
  endfunction

  function automatic int oh_idx(logic [N-1:0] v);
    int r;
    int c;
    r = -1;
    c = 0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        r = i;
        c++;
      end
    end
    return (c == 1) ? r : -1;
  endfunction

  always_comb begin
    s_data  = '0;
    s_valid = '0;
    s_last  = '0;
    s_user  = '0;
    for (int k = 0; k < N; k++) begin
      s_valid[k]        = done[k] < nreq[k];
      s_last[k]         = pos[k] == flen[k] - 1;
      s_data[k*8 +: 8]  = pat(k, done[k], pos[k]);
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < N; k++) hs[k] = s_valid[k] & s_ready[k];
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < N; k++) begin
      if (hs[k] && rst_n) begin
        if (pos[k] == flen[k] - 1) begin
          pos[k]  <= 0;
          done[k] <= done[k] + 1;
        end else begin
          pos[k] <= pos[k] + 1;
        end
      end
    end
  end

  typedef struct {
    int         src;
    logic [7:0] d;
    logic       l;
    logic       u;
    int         c;
  } beat_t;

  beat_t q[$];
  beat_t mb;
  int    drain_cyc = 0;
  int    rdy_bad = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (mac.tvalid && mac.tready) begin
        mb.src = oh_idx(grant);
        mb.d   = mac.tdata;
        mb.l   = mac.tlast;
        mb.u   = mac.tuser;
        mb.c   = cyc;
        q.push_back(mb);
      end
      if (busy && !mac.tvalid) drain_cyc++;
      if (busy && mac.tvalid && s_ready != (grant & {N{mac.tready}}))
        rdy_bad++;
    end
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic req(int k, int len);
    flen[k] = len;
    nreq[k] = nreq[k] + 1;
  endtask

  task automatic wait_grant();
    int t;
    t = 0;
    while (grant == '0 && t < 200) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic check_frame(string tag, int k, int len, bit abrt,
                             output int c0, output int c1);
    int    t;
    int    f;
    beat_t b;
    t  = 0;
    c0 = 0;
    c1 = 0;
    while (q.size() < len && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (q.size() < len) begin
      chk({tag, "_timeout"}, q.size(), len);
      return;
    end
    f = nf[k];
    nf[k]++;
    for (int p = 0; p < len; p++) begin
      b = q.pop_front();
      if (p == 0) c0 = b.c;
      if (p == len - 1) c1 = b.c;
      chk($sformatf("%s_b%0d", tag, p),
          {b.src[7:0], b.d, 7'd0, b.l, 7'd0, b.u},
          {8'(k), pat(k, f, p), 7'd0, 1'(p == len - 1),
           7'd0, 1'(abrt && p == len - 1)});
    end
  endtask

  initial begin
    int c0, c1, pc1, d0, t;
    cfg_en   = 1'b1;
    cfg_mask = '1;
    rst_n    = 1'b0;
    tick(2);
    @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sent", n_sent, 0);
    chk("rst_abort", n_abort, 0);
    chk("rst_mvalid", mac.tvalid, 0);
    chk("rst_srdy", s_ready, 0);
    rst_n = 1'b1;
    tick(2);

    // all four request, 10-byte frames, src0 twice
    req(0, 10); req(0, 10); req(1, 10); req(2, 10); req(3, 10);
    check_frame("rr0", 0, 10, 0, c0, pc1);
    check_frame("rr1", 1, 10, 0, c0, c1);
    chk("rr1_gap", c0 - pc1, 2); pc1 = c1;
    check_frame("rr2", 2, 10, 0, c0, c1);
    chk("rr2_gap", c0 - pc1, 2); pc1 = c1;
    check_frame("rr3", 3, 10, 0, c0, c1);
    chk("rr3_gap", c0 - pc1, 2); pc1 = c1;
    check_frame("rr4", 0, 10, 0, c0, c1);
    chk("rr4_gap", c0 - pc1, 2);
    tick(3);
    chk("rr_sent", n_sent, 5);

    // single frame, grant latency
    req(1, 16);
    @(negedge clk);
    chk("lat_g0", grant, 0);
    @(negedge clk);
    chk("lat_g1", grant, 4'b0010);
    check_frame("f16", 1, 16, 0, c0, c1);
    tick(2);
    chk("f16_sent", n_sent, 6);

    // over-length frame on src2, src3 queued behind it
    d0 = drain_cyc;
    req(2, 30); req(3, 5);
    check_frame("abrt", 2, MAXL, 1, c0, c1);
    check_frame("post", 3, 5, 0, c0, c1);
    tick(2);
    chk("abrt_cnt", n_abort, 1);
    chk("abrt_drain", drain_cyc - d0, 10);
    chk("abrt_src_done", done[2], 2);
    chk("abrt_sent", n_sent, 7);

    // exactly MAX beats with tlast: normal, counter saturates at 7
    req(0, MAXL);
    check_frame("max", 0, MAXL, 0, c0, c1);
    tick(2);
    chk("max_sent_sat", n_sent, 7);
    chk("max_abort", n_abort, 1);

    // toggling MAC ready
    tog = 1'b1;
    req(1, 16);
    check_frame("tog", 1, 16, 0, c0, c1);
    tick(3);
    chk("tog_extra", q.size(), 0);
    chk("tog_rdy", rdy_bad, 0);
    tog = 1'b0;

    // masked source
    cfg_mask = 4'b1011;
    req(2, 6);
    tick(10);
    chk("mask_grant", grant, 0);
    chk("mask_beats", q.size(), 0);
    cfg_mask = '1;
    check_frame("unmask", 2, 6, 0, c0, c1);

    // enable cleared mid-frame
    req(0, 10);
    wait_grant();
    chk("en_grant", grant, 4'b0001);
    cfg_en = 1'b0;
    req(1, 4);
    check_frame("en_f0", 0, 10, 0, c0, c1);
    tick(10);
    chk("en_hold_grant", grant, 0);
    chk("en_hold_busy", busy, 0);
    cfg_en = 1'b1;
    check_frame("en_f1", 1, 4, 0, c0, c1);

    // async reset mid-frame after beat 5
    req(0, 4);
    check_frame("pre", 0, 4, 0, c0, c1);
    tick(2);
    req(1, 10); req(0, 4);
    t = 0;
    while (q.size() < 5 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("mid_src", oh_idx(grant), 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_grant", grant, 0);
    chk("arst_busy", busy, 0);
    chk("arst_mac", {mac.tvalid, mac.tlast, mac.tuser, mac.tdata}, 0);
    chk("arst_srdy", s_ready, 0);
    chk("arst_cnt", {n_sent, n_abort}, 0);
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_grant();
    chk("arst_first", grant, 4'b0001);
    check_frame("arst_f0", 0, 4, 0, c0, c1);
    t = 0;
    while ((busy || done[1] < nreq[1]) && t < 200) begin
      @(negedge clk);
      t++;
    end
    tick(2);
    chk("end_busy", busy, 0);
    chk("end_sent", n_sent, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
